// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS checker/generator family.
// Holds the lock FSM encoding, standard polynomial taps and default seeds.
package prbs_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ALIGN  = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } prbs_state_e;

  // Polynomials x^LEN + x^TAP + 1
  localparam int PRBS7_LEN  = 7;
  localparam int PRBS7_TAP  = 6;
  localparam int PRBS11_LEN = 11;
  localparam int PRBS11_TAP = 9;
  localparam int PRBS15_LEN = 15;
  localparam int PRBS15_TAP = 14;
  localparam int PRBS23_LEN = 23;
  localparam int PRBS23_TAP = 18;
  localparam int PRBS31_LEN = 31;
  localparam int PRBS31_TAP = 28;

  localparam logic [6:0]  PRBS7_SEED  = 7'h40;
  localparam logic [10:0] PRBS11_SEED = 11'h400;
  localparam logic [14:0] PRBS15_SEED = 15'h4000;
  localparam logic [22:0] PRBS23_SEED = 23'h40_0000;
  localparam logic [30:0] PRBS31_SEED = 31'h4000_0000;

endpackage

// File: rtl/prbs_lfsr_next.sv
// Combinational feedback and free-running next state of a Fibonacci LFSR.
// Shared between the PRBS checker and the PRBS generator.
module prbs_lfsr_next
  import prbs_pkg::*;
#(
  parameter int LFSR_LEN = PRBS11_LEN,
  parameter int TAP_B    = PRBS11_TAP
) (
  input  logic [LFSR_LEN-1:0] state,
  output logic                fb,
  output logic [LFSR_LEN-1:0] next_state
);

  assign fb         = state[LFSR_LEN-1] ^ state[TAP_B-1];
  assign next_state = {state[LFSR_LEN-2:0], fb};

endmodule

// File: rtl/prbs_checker.sv
// Parametrised serial PRBS checker: self-aligns, locks, counts bit errors.
// Optional output err_pulse is present when PRBS_CHK_ERR_PULSE_EN is defined.
module prbs_checker
  import prbs_pkg::*;
#(
  parameter int                  LFSR_LEN  = PRBS11_LEN,
  parameter int                  TAP_B     = PRBS11_TAP,
  parameter logic [LFSR_LEN-1:0] SEED      = {1'b1, {(LFSR_LEN-1){1'b0}}},
  parameter int                  LOCK_CNT  = 16,
  parameter int                  LOSS_ERRS = 4,
  parameter int                  ERR_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 invert,
  input  logic                 data_in,
  input  logic                 clear_err,
  output logic                 locked,
  output logic                 seq_ok,
  output logic [ERR_CNT_W-1:0] err_cnt,
`ifdef PRBS_CHK_ERR_PULSE_EN
  output logic                 err_pulse,
`endif
  output logic                 err_sat
);

  localparam int ALIGN_W = $clog2(LFSR_LEN);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int PER_W   = $clog2(LOSS_ERRS + 1);

  localparam logic [ALIGN_W-1:0]   ALIGN_LAST = ALIGN_W'(LFSR_LEN - 1);
  localparam logic [MATCH_W-1:0]   MATCH_LAST = MATCH_W'(LOCK_CNT);
  localparam logic [PER_W-1:0]     PER_LOSS   = PER_W'(LOSS_ERRS);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX    = {ERR_CNT_W{1'b1}};

  prbs_state_e          state_r;
  logic [LFSR_LEN-1:0]  lfsr_r;
  logic [ALIGN_W-1:0]   align_cnt_r;
  logic [MATCH_W-1:0]   match_cnt_r;
  logic [PER_W-1:0]     per_err_r;

  logic                 d_s;
  logic                 fb_s;
  logic                 mis_s;
  logic                 err_hit_s;
  logic [LFSR_LEN-1:0]  lfsr_fb_s;
  logic [LFSR_LEN-1:0]  lfsr_d_s;
  logic [MATCH_W-1:0]   match_inc_s;
  logic [PER_W-1:0]     per_inc_s;
  logic [ERR_CNT_W-1:0] err_cnt_nx_s;

  prbs_lfsr_next #(
    .LFSR_LEN (LFSR_LEN),
    .TAP_B    (TAP_B)
  ) u_next (
    .state      (lfsr_r),
    .fb         (fb_s),
    .next_state (lfsr_fb_s)
  );

  assign d_s          = data_in ^ invert;
  assign mis_s        = d_s ^ fb_s;
  assign lfsr_d_s     = {lfsr_r[LFSR_LEN-2:0], d_s};
  assign match_inc_s  = match_cnt_r + 1'b1;
  assign per_inc_s    = per_err_r + 1'b1;
  assign err_hit_s    = enable & (state_r == ST_LOCKED) & mis_s;
  assign err_cnt_nx_s = (err_cnt == ERR_MAX) ? err_cnt : err_cnt + 1'b1;

  // Lock state machine, reference LFSR and per-period error bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= SEED;
      align_cnt_r <= '0;
      match_cnt_r <= '0;
      per_err_r   <= '0;
      locked      <= 1'b0;
      seq_ok      <= 1'b0;
    end else if (!enable) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= SEED;
      align_cnt_r <= '0;
      match_cnt_r <= '0;
      per_err_r   <= '0;
      locked      <= 1'b0;
      seq_ok      <= 1'b0;
    end else begin
      seq_ok <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          state_r     <= ST_ALIGN;
          align_cnt_r <= '0;
        end
        ST_ALIGN: begin
          lfsr_r <= lfsr_d_s;
          if (align_cnt_r == ALIGN_LAST) begin
            align_cnt_r <= '0;
            // An all-zero window would lock the LFSR up, so keep loading
            if (lfsr_d_s != '0) begin
              state_r     <= ST_VERIFY;
              match_cnt_r <= '0;
            end
          end else begin
            align_cnt_r <= align_cnt_r + 1'b1;
          end
        end
        ST_VERIFY: begin
          if (mis_s) begin
            state_r     <= ST_ALIGN;
            align_cnt_r <= '0;
          end else begin
            lfsr_r      <= lfsr_fb_s;
            match_cnt_r <= match_inc_s;
            if (match_inc_s == MATCH_LAST) begin
              state_r   <= ST_LOCKED;
              locked    <= 1'b1;
              per_err_r <= '0;
            end
          end
        end
        ST_LOCKED: begin
          lfsr_r <= lfsr_fb_s;
          if (mis_s && (per_inc_s == PER_LOSS)) begin
            state_r     <= ST_ALIGN;
            align_cnt_r <= '0;
            per_err_r   <= '0;
            locked      <= 1'b0;
          end else if (lfsr_fb_s == SEED) begin
            seq_ok    <= ~mis_s & (per_err_r == '0);
            per_err_r <= '0;
          end else if (mis_s) begin
            per_err_r <= per_inc_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating error counter; clear_err beats a same-cycle mismatch.
  always_ff @(posedge clk) begin
    if (reset || clear_err) begin
      err_cnt <= '0;
      err_sat <= 1'b0;
    end else if (err_hit_s) begin
      err_cnt <= err_cnt_nx_s;
      err_sat <= err_sat | (err_cnt_nx_s == ERR_MAX);
    end
  end

`ifdef PRBS_CHK_ERR_PULSE_EN
  // One-cycle pulse per locked mismatch, blind to saturation and clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= err_hit_s;
    end
  end
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Scoreboard bench for prbs_checker (PRBS11, 4-bit error counter).
// Stimulus predicts every locked edge and seq_ok pulse; a monitor checks them.
`timescale 1ns/1ps
module tb_prbs_checker;

  localparam int ERR_W   = 4;
  localparam int ERR_MAX = 15;

  logic clk = 1'b0;
  logic reset, enable, invert, data_in, clear_err;
  logic locked, seq_ok, err_sat;
  logic [ERR_W-1:0] err_cnt;
`ifdef PRBS_CHK_ERR_PULSE_EN
  logic err_pulse;
`endif

  typedef struct {
    int cyc_e;
    int lk;
    int sq;
    int ec;
    int es;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Transmitter state and expectation tracking
  logic [10:0] g = 11'h2B5;
  bit m_locked = 1'b0, prev_en = 1'b0, en_m = 1'b0;
  bit inv_cfg = 1'b0, stream_inv = 1'b0, zero_stream = 1'b0, lockable = 1'b1;
  int lock_edge = -1, per_m = 0, err_m = 0, sat_m = 0;

  prbs_checker #(
    .LFSR_LEN  (11),
    .TAP_B     (9),
    .SEED      (11'h400),
    .LOCK_CNT  (16),
    .LOSS_ERRS (4),
    .ERR_CNT_W (ERR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .invert    (invert),
    .data_in   (data_in),
    .clear_err (clear_err),
    .locked    (locked),
    .seq_ok    (seq_ok),
    .err_cnt   (err_cnt),
`ifdef PRBS_CHK_ERR_PULSE_EN
    .err_pulse (err_pulse),
`endif
    .err_sat   (err_sat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Drive one bit and push the expected outcome for that edge when notable.
  task automatic send_one(input bit flip, input bit clr, input bit rst, input bit prb);
    exp_t e;
    bit   b, mis, was;
    int   k;
    b = g[10] ^ g[8];
    g = {g[9:0], b};
    reset     = rst;
    enable    = en_m;
    invert    = inv_cfg;
    clear_err = clr;
    data_in   = zero_stream ? 1'b0 : (b ^ flip ^ stream_inv);
    k   = cyc + 1;
    was = m_locked;
    e   = '{0, 0, 0, 0, 0};
    if (rst) begin
      m_locked = 1'b0; prev_en = 1'b0; lock_edge = -1;
      per_m = 0; err_m = 0; sat_m = 0;
    end else begin
      if (!en_m) begin
        m_locked = 1'b0; prev_en = 1'b0; lock_edge = -1; per_m = 0;
      end else if (!prev_en) begin
        prev_en   = 1'b1;
        lock_edge = lockable ? k + 27 : -1;
      end
      mis = m_locked && flip;
      if (clr) begin
        err_m = 0; sat_m = 0;
      end else if (mis) begin
        if (err_m != ERR_MAX) err_m++;
        if (err_m == ERR_MAX) sat_m = 1;
      end
      if (m_locked) begin
        if (mis) per_m++;
        if (per_m == 4) begin
          m_locked = 1'b0; per_m = 0; lock_edge = k + 27;
        end else if (g == 11'h400) begin
          e.sq  = (per_m == 0) ? 1 : 0;
          per_m = 0;
        end
      end else if (k == lock_edge) begin
        m_locked = 1'b1;
      end
    end
    if (prb || (m_locked != was) || (e.sq != 0)) begin
      e.cyc_e = k;
      e.lk    = m_locked ? 1 : 0;
      e.ec    = err_m;
      e.es    = sat_m;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) send_one(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic to_boundary();
    for (int i = 0; i < 2100 && g != 11'h400; i++) send_one(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Four flips well inside one period: forces loss of lock on the last.
  task automatic burst4();
    clean(30);
    to_boundary();
    clean(5);
    for (int i = 0; i < 4; i++) begin
      send_one(1'b1, 1'b0, 1'b0, 1'b0);
      send_one(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Monitor: every locked edge, seq_ok pulse or probe cycle must match the queue.
  initial begin : monitor
    logic prev_lk;
    exp_t e;
    prev_lk = 1'b0;
    forever begin
      @(negedge clk);
      if (seq_ok === 1'b1 || locked !== prev_lk || (q.size() > 0 && q[0].cyc_e == cyc)) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event at cycle %0d: locked=%0b seq_ok=%0b, none expected",
                   cyc, locked, seq_ok);
        end else begin
          e = q.pop_front();
          chk("event_cycle", cyc, e.cyc_e);
          chk("locked", int'(locked), e.lk);
          chk("seq_ok", int'(seq_ok), e.sq);
          chk("err_cnt", int'(err_cnt), e.ec);
          chk("err_sat", int'(err_sat), e.es);
        end
      end
      prev_lk = locked;
    end
  end

  initial begin
    reset = 1'b1; enable = 1'b0; invert = 1'b0; data_in = 1'b0; clear_err = 1'b0;
    // Reset state
    send_one(1'b0, 1'b0, 1'b1, 1'b0);
    send_one(1'b0, 1'b0, 1'b1, 1'b1);
    clean(5);
    // Clean stream from arbitrary phase: lock after 27 bits, seq_ok every 2047
    en_m = 1'b1;
    clean(27 + 2 * 2047 + 40);
    // Single flip: that period has no seq_ok, the next one does
    to_boundary();
    clean(100);
    send_one(1'b1, 1'b0, 1'b0, 1'b0);
    clean(2 * 2047 + 10);
    send_one(1'b0, 1'b0, 1'b0, 1'b1);
    send_one(1'b0, 1'b1, 1'b0, 1'b1);
    // Four flips per period, repeated until the 4-bit counter saturates
    for (int r = 0; r < 4; r++) begin
      burst4();
      clean(40);
    end
    send_one(1'b0, 1'b0, 1'b0, 1'b1);
    // clear_err together with a mismatch
    send_one(1'b1, 1'b1, 1'b0, 1'b1);
    clean(5);
    // Disable drops lock, err_cnt kept
    en_m = 1'b0;
    clean(3);
    send_one(1'b0, 1'b0, 1'b0, 1'b1);
    // Complemented stream with invert=1 locks
    stream_inv = 1'b1; inv_cfg = 1'b1; en_m = 1'b1;
    clean(27 + 2100);
    // Complemented stream with invert=0 never locks
    en_m = 1'b0;
    clean(3);
    inv_cfg = 1'b0; lockable = 1'b0; en_m = 1'b1;
    clean(300);
    // All-zero input stays in ALIGN
    zero_stream = 1'b1; en_m = 1'b0;
    clean(2);
    en_m = 1'b1;
    clean(300);
    send_one(1'b0, 1'b0, 1'b0, 1'b1);
    // Reset mid-operation with enable held high
    zero_stream = 1'b0; inv_cfg = 1'b1; lockable = 1'b1; en_m = 1'b0;
    clean(2);
    en_m = 1'b1;
    clean(60);
    send_one(1'b1, 1'b0, 1'b0, 1'b0);
    clean(3);
    send_one(1'b0, 1'b0, 1'b1, 1'b1);
    clean(40);
    clean(5);
    chk("pending_expectations", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
